// File: rtl/exe_stage.sv
// Execute stage of the ARM-subset pipeline: Val2 shifter, ALU, branch adder, NZCV and EXE/MEM registers.
// Optional operand forwarding muxes are enabled with `define FORWARDING_EN.
module exe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic [WIDTH-1:0] PC_in,
  input  logic             wb_enable_in,
  input  logic             mem_read_in,
  input  logic             mem_write_in,
  input  logic             B_in,
  input  logic             S_in,
  input  logic             imm_in,
  input  logic [3:0]       exec_cmd_in,
  input  logic [WIDTH-1:0] val_Rn_in,
  input  logic [WIDTH-1:0] val_Rm_in,
  input  logic [3:0]       Rd_in,
  input  logic [11:0]      shift_operand_in,
  input  logic [23:0]      signed_imm_24_in,
  output logic             branch_taken,
  output logic [WIDTH-1:0] branch_address,
  output logic [3:0]       status_out,
  output logic             wb_enable_out,
  output logic             mem_read_out,
  output logic             mem_write_out,
  output logic [WIDTH-1:0] alu_result_out,
  output logic [WIDTH-1:0] val_Rm_out,
  output logic [3:0]       Rd_out
`ifdef FORWARDING_EN
  ,
  input  logic [1:0]       sel_src1,
  input  logic [1:0]       sel_src2,
  input  logic [WIDTH-1:0] mem_fwd_val,
  input  logic [WIDTH-1:0] wb_fwd_val
`endif
);

  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
    return (x >> n) | (x << (6'd32 - {1'b0, n}));
  endfunction

  logic [31:0] rn_s;
  logic [31:0] rm_s;
  logic [31:0] val2_s;
  logic [31:0] opb_s;
  logic        cin_sel_s;
  logic        arith_s;
  logic [32:0] sum_s;
  logic [31:0] alu_res_s;
  logic [3:0]  flags_s;

  logic [3:0]  status_r;
  logic        wb_enable_r;
  logic        mem_read_r;
  logic        mem_write_r;
  logic [31:0] alu_result_r;
  logic [31:0] val_Rm_r;
  logic [3:0]  Rd_r;

`ifdef FORWARDING_EN
  // Operand source selection between ID value and the two forwarding paths
  always_comb begin
    rn_s = val_Rn_in;
    rm_s = val_Rm_in;
    case (sel_src1)
      2'b01:   rn_s = mem_fwd_val;
      2'b10:   rn_s = wb_fwd_val;
      default: rn_s = val_Rn_in;
    endcase
    case (sel_src2)
      2'b01:   rm_s = mem_fwd_val;
      2'b10:   rm_s = wb_fwd_val;
      default: rm_s = val_Rm_in;
    endcase
  end
`else
  assign rn_s = val_Rn_in;
  assign rm_s = val_Rm_in;
`endif

  assign branch_taken   = B_in;
  assign branch_address = PC_in + {{6{signed_imm_24_in[23]}}, signed_imm_24_in, 2'b00};

  // Val2 generation: rotated immediate, memory offset, or shifted Rm
  always_comb begin
    val2_s = rm_s;
    if (imm_in) begin
      val2_s = ror32({24'd0, shift_operand_in[7:0]}, {shift_operand_in[11:8], 1'b0});
    end else if (mem_read_in | mem_write_in) begin
      val2_s = {20'd0, shift_operand_in};
    end else begin
      case (shift_operand_in[6:5])
        2'b00:   val2_s = rm_s << shift_operand_in[11:7];
        2'b01:   val2_s = rm_s >> shift_operand_in[11:7];
        2'b10:   val2_s = $signed(rm_s) >>> shift_operand_in[11:7];
        2'b11:   val2_s = ror32(rm_s, shift_operand_in[11:7]);
        default: val2_s = rm_s;
      endcase
    end
  end

  // Adder operand decode; subtraction is Rn + ~Val2 + carry
  always_comb begin
    arith_s   = 1'b0;
    opb_s     = val2_s;
    cin_sel_s = 1'b0;
    case (exec_cmd_in)
      4'b0010: begin arith_s = 1'b1; opb_s = val2_s;  cin_sel_s = 1'b0;        end
      4'b0011: begin arith_s = 1'b1; opb_s = val2_s;  cin_sel_s = status_r[1]; end
      4'b0100: begin arith_s = 1'b1; opb_s = ~val2_s; cin_sel_s = 1'b1;        end
      4'b0101: begin arith_s = 1'b1; opb_s = ~val2_s; cin_sel_s = status_r[1]; end
      default: begin arith_s = 1'b0; opb_s = val2_s;  cin_sel_s = 1'b0;        end
    endcase
  end

  assign sum_s = {1'b0, rn_s} + {1'b0, opb_s} + {32'd0, cin_sel_s};

  // ALU result select and NZCV generation; non-arithmetic ops keep C and V
  always_comb begin
    alu_res_s = 32'd0;
    case (exec_cmd_in)
      4'b0001: alu_res_s = val2_s;
      4'b1001: alu_res_s = ~val2_s;
      4'b0010, 4'b0011, 4'b0100, 4'b0101: alu_res_s = sum_s[31:0];
      4'b0110: alu_res_s = rn_s & val2_s;
      4'b0111: alu_res_s = rn_s | val2_s;
      4'b1000: alu_res_s = rn_s ^ val2_s;
      default: alu_res_s = 32'd0;
    endcase
    flags_s[3] = alu_res_s[31];
    flags_s[2] = (alu_res_s == 32'd0);
    if (arith_s) begin
      flags_s[1] = sum_s[32];
      flags_s[0] = (rn_s[31] == opb_s[31]) && (sum_s[31] != rn_s[31]);
    end else begin
      flags_s[1] = status_r[1];
      flags_s[0] = status_r[0];
    end
  end

  // NZCV status register
  always_ff @(posedge clk) begin
    if (rst) begin
      status_r <= 4'b0000;
    end else if (S_in && !freeze) begin
      status_r <= flags_s;
    end else begin
      status_r <= status_r;
    end
  end

  // EXE/MEM pipeline register, held during memory stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_enable_r  <= 1'b0;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      alu_result_r <= 32'd0;
      val_Rm_r     <= 32'd0;
      Rd_r         <= 4'd0;
    end else if (!freeze) begin
      wb_enable_r  <= wb_enable_in;
      mem_read_r   <= mem_read_in;
      mem_write_r  <= mem_write_in;
      alu_result_r <= alu_res_s;
      val_Rm_r     <= rm_s;
      Rd_r         <= Rd_in;
    end else begin
      wb_enable_r  <= wb_enable_r;
      mem_read_r   <= mem_read_r;
      mem_write_r  <= mem_write_r;
      alu_result_r <= alu_result_r;
      val_Rm_r     <= val_Rm_r;
      Rd_r         <= Rd_r;
    end
  end

  assign status_out     = status_r;
  assign wb_enable_out  = wb_enable_r;
  assign mem_read_out   = mem_read_r;
  assign mem_write_out  = mem_write_r;
  assign alu_result_out = alu_result_r;
  assign val_Rm_out     = val_Rm_r;
  assign Rd_out         = Rd_r;

endmodule
